// File: rtl/rv32i_axi_pkg.sv
// Shared types and constants for the rv32i AXI4-Lite master bridge.
package rv32i_axi_pkg;

   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;
   localparam logic [1:0] DECERR = 2'b11;

   localparam logic [2:0] PROT_INSN = 3'b100;
   localparam logic [2:0] PROT_DATA = 3'b000;

   typedef enum logic [1:0] {
      SIZE_BYTE = 2'b00,
      SIZE_HALF = 2'b01,
      SIZE_WORD = 2'b10,
      SIZE_ILL  = 2'b11
   } mem_size_t;

   typedef enum logic [2:0] {
      IDLE,
      RD_ADDR,
      RD_DATA,
      WR_REQ,
      WR_RESP,
      RESP
   } state_t;

endpackage

// File: rtl/rv32i_lsu_align.sv
// Combinational LSU helper: misalignment check, store lane formatting and
// load byte/half extraction with sign or zero extension.
module rv32i_lsu_align
   import rv32i_axi_pkg::*;
(
   input  logic        is_data,
   input  logic [1:0]  req_offset,
   input  mem_size_t   req_size,
   input  logic [31:0] store_data,
   output logic        misaligned,
   output logic [3:0]  wstrb,
   output logic [31:0] wdata,
   input  logic [1:0]  ld_offset,
   input  mem_size_t   ld_size,
   input  logic        ld_unsigned,
   input  logic [31:0] rdata,
   output logic [31:0] load_data
);

   logic [31:0] shifted;

   always_comb begin
      misaligned = 1'b0;
      wstrb      = '0;
      wdata      = '0;
      if (!is_data) begin
         misaligned = (req_offset != 2'b00);
      end else begin
         case (req_size)
            SIZE_BYTE: misaligned = 1'b0;
            SIZE_HALF: misaligned = req_offset[0];
            SIZE_WORD: misaligned = |req_offset;
            default:   misaligned = 1'b1;
         endcase
      end
      case (req_size)
         SIZE_BYTE: begin
            wstrb = 4'b0001 << req_offset;
            wdata = {4{store_data[7:0]}};
         end
         SIZE_HALF: begin
            wstrb = 4'b0011 << req_offset;
            wdata = {2{store_data[15:0]}};
         end
         SIZE_WORD: begin
            wstrb = 4'b1111;
            wdata = store_data;
         end
         default: begin
            wstrb = '0;
            wdata = '0;
         end
      endcase
   end

   always_comb begin
      shifted   = rdata >> {ld_offset, 3'b000};
      load_data = rdata;
      case (ld_size)
         SIZE_BYTE: load_data = ld_unsigned ? {24'h0, shifted[7:0]}
                                            : {{24{shifted[7]}}, shifted[7:0]};
         SIZE_HALF: load_data = ld_unsigned ? {16'h0, shifted[15:0]}
                                            : {{16{shifted[15]}}, shifted[15:0]};
         default:   load_data = rdata;
      endcase
   end

endmodule

// File: rtl/rv32i_axi_master.sv
// AXI4-Lite master bridge: serialises core fetch/load/store requests onto one
// bus port, one transaction at a time, with local misalign and timeout errors.
module rv32i_axi_master
   import rv32i_axi_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 0,
   parameter logic [1:0]  ERR_RESP       = SLVERR
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_arvalid,
   input  logic        req_rready,
   input  logic        req_awvalid,
   input  logic        req_wvalid,
   input  logic        req_bready,
   input  logic        data_access,
   input  logic [31:0] pc,
   input  logic [31:0] data_addr,
   input  logic [31:0] store_data,
   input  logic [1:0]  mem_size,
   input  logic        mem_unsigned,
   output logic        core_arready,
   output logic        core_rvalid,
   output logic [1:0]  core_rresp,
   output logic        core_awready,
   output logic        core_wready,
   output logic        core_bvalid,
   output logic [1:0]  core_bresp,
   output logic [31:0] instr_rdata,
   output logic [31:0] load_data,
   output logic [31:0] m_axi_araddr,
   output logic [2:0]  m_axi_arprot,
   output logic        m_axi_arvalid,
   input  logic        m_axi_arready,
   input  logic [31:0] m_axi_rdata,
   input  logic [1:0]  m_axi_rresp,
   input  logic        m_axi_rvalid,
   output logic        m_axi_rready,
   output logic [31:0] m_axi_awaddr,
   output logic [2:0]  m_axi_awprot,
   output logic        m_axi_awvalid,
   input  logic        m_axi_awready,
   output logic [31:0] m_axi_wdata,
   output logic [3:0]  m_axi_wstrb,
   output logic        m_axi_wvalid,
   input  logic        m_axi_wready,
   input  logic [1:0]  m_axi_bresp,
   input  logic        m_axi_bvalid,
   output logic        m_axi_bready
);

   localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

   state_t        state, state_n;
   logic [TW-1:0] timer;
   logic [31:0]   addr_q, wdata_q, rdata_q, wdata_fmt, req_addr;
   logic [3:0]    wstrb_q, wstrb_fmt;
   logic [2:0]    arprot_q;
   logic [1:0]    off_q, resp_q;
   mem_size_t     size_q;
   logic          uns_q, is_write_q, aw_done, w_done;
   logic          is_data, misaligned, timeout_hit;
   logic          accept, timed_out, aw_hs, w_hs, cap_r, cap_b;
   logic          unused_ok;

   // Core responses are single-cycle pulses; the core-side readies and the
   // separate write-data request carry no extra information here.
   assign unused_ok = &{1'b0, req_rready, req_bready, req_wvalid};

   assign is_data     = data_access | req_awvalid;
   assign req_addr    = is_data ? data_addr : pc;
   assign timeout_hit = (TIMEOUT_CYCLES != 0) && (timer == TW'(TIMEOUT_CYCLES - 1));

   rv32i_lsu_align u_align (
      .is_data     (is_data),
      .req_offset  (req_addr[1:0]),
      .req_size    (mem_size_t'(mem_size)),
      .store_data  (store_data),
      .misaligned  (misaligned),
      .wstrb       (wstrb_fmt),
      .wdata       (wdata_fmt),
      .ld_offset   (off_q),
      .ld_size     (size_q),
      .ld_unsigned (uns_q),
      .rdata       (rdata_q),
      .load_data   (load_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n       = state;
      accept        = 1'b0;
      timed_out     = 1'b0;
      aw_hs         = 1'b0;
      w_hs          = 1'b0;
      cap_r         = 1'b0;
      cap_b         = 1'b0;
      m_axi_arvalid = 1'b0;
      m_axi_rready  = 1'b0;
      m_axi_awvalid = 1'b0;
      m_axi_wvalid  = 1'b0;
      m_axi_bready  = 1'b0;
      core_arready  = 1'b0;
      core_awready  = 1'b0;
      core_wready   = 1'b0;
      core_rvalid   = 1'b0;
      core_bvalid   = 1'b0;
      case (state)
         IDLE: if (req_awvalid || req_arvalid) begin
            accept = 1'b1;
            if (misaligned)       state_n = RESP;
            else if (req_awvalid) state_n = WR_REQ;
            else                  state_n = RD_ADDR;
         end
         RD_ADDR: begin
            m_axi_arvalid = 1'b1;
            if (m_axi_arready) begin
               core_arready = 1'b1;
               state_n      = RD_DATA;
            end else if (timeout_hit) begin
               timed_out = 1'b1;
               state_n   = RESP;
            end
         end
         RD_DATA: begin
            m_axi_rready = 1'b1;
            if (m_axi_rvalid) begin
               cap_r   = 1'b1;
               state_n = RESP;
            end else if (timeout_hit) begin
               timed_out = 1'b1;
               state_n   = RESP;
            end
         end
         WR_REQ: begin
            m_axi_awvalid = !aw_done;
            m_axi_wvalid  = !w_done;
            aw_hs         = !aw_done && m_axi_awready;
            w_hs          = !w_done && m_axi_wready;
            core_awready  = aw_hs;
            core_wready   = w_hs;
            if ((aw_done || aw_hs) && (w_done || w_hs)) begin
               state_n = WR_RESP;
            end else if (timeout_hit) begin
               timed_out = 1'b1;
               state_n   = RESP;
            end
         end
         WR_RESP: begin
            m_axi_bready = 1'b1;
            if (m_axi_bvalid) begin
               cap_b   = 1'b1;
               state_n = RESP;
            end else if (timeout_hit) begin
               timed_out = 1'b1;
               state_n   = RESP;
            end
         end
         RESP: begin
            core_rvalid = !is_write_q;
            core_bvalid = is_write_q;
            state_n     = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // Timer restarts on every state change, so each wait state gets a fresh budget.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                              timer <= '0;
      else if (state_n != state)               timer <= '0;
      else if (timer != TW'(TIMEOUT_CYCLES))   timer <= timer + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q     <= '0;
         off_q      <= '0;
         size_q     <= SIZE_BYTE;
         uns_q      <= 1'b0;
         arprot_q   <= '0;
         wstrb_q    <= '0;
         wdata_q    <= '0;
         rdata_q    <= '0;
         resp_q     <= '0;
         is_write_q <= 1'b0;
         aw_done    <= 1'b0;
         w_done     <= 1'b0;
      end else begin
         if (accept) begin
            addr_q     <= {req_addr[31:2], 2'b00};
            off_q      <= req_addr[1:0];
            size_q     <= is_data ? mem_size_t'(mem_size) : SIZE_WORD;
            uns_q      <= mem_unsigned;
            arprot_q   <= is_data ? PROT_DATA : PROT_INSN;
            wstrb_q    <= wstrb_fmt;
            wdata_q    <= wdata_fmt;
            rdata_q    <= '0;
            resp_q     <= misaligned ? ERR_RESP : OKAY;
            is_write_q <= req_awvalid;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
         end
         if (aw_hs) aw_done <= 1'b1;
         if (w_hs)  w_done  <= 1'b1;
         if (cap_r) begin
            rdata_q <= m_axi_rdata;
            resp_q  <= m_axi_rresp;
         end
         if (cap_b)     resp_q <= m_axi_bresp;
         if (timed_out) resp_q <= DECERR;
      end
   end

   assign core_rresp   = resp_q;
   assign core_bresp   = resp_q;
   assign instr_rdata  = rdata_q;
   assign m_axi_araddr = addr_q;
   assign m_axi_arprot = arprot_q;
   assign m_axi_awaddr = addr_q;
   assign m_axi_awprot = PROT_DATA;
   assign m_axi_wdata  = wdata_q;
   assign m_axi_wstrb  = wstrb_q;

endmodule

// File: tb/tb_rv32i_axi_master.sv
// Directed self-checking bench for rv32i_axi_master with a scripted AXI slave.
module tb_rv32i_axi_master;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_arvalid, req_rready, req_awvalid, req_wvalid, req_bready;
   logic        data_access, mem_unsigned;
   logic [31:0] pc, data_addr, store_data;
   logic [1:0]  mem_size;
   logic        core_arready, core_rvalid, core_awready, core_wready, core_bvalid;
   logic [1:0]  core_rresp, core_bresp;
   logic [31:0] instr_rdata, load_data;
   logic [31:0] m_axi_araddr, m_axi_rdata, m_axi_awaddr, m_axi_wdata;
   logic [2:0]  m_axi_arprot, m_axi_awprot;
   logic        m_axi_arvalid, m_axi_arready, m_axi_rvalid, m_axi_rready;
   logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
   logic        m_axi_bvalid, m_axi_bready;
   logic [1:0]  m_axi_rresp, m_axi_bresp;
   logic [3:0]  m_axi_wstrb;

   int vectors = 0;
   int miscompares = 0;
   int ar_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0, rv_cnt = 0, bv_cnt = 0;

   always #5 clk = ~clk;

   rv32i_axi_master #(.TIMEOUT_CYCLES(8), .ERR_RESP(2'b10)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_arvalid(req_arvalid), .req_rready(req_rready), .req_awvalid(req_awvalid),
      .req_wvalid(req_wvalid), .req_bready(req_bready), .data_access(data_access),
      .pc(pc), .data_addr(data_addr), .store_data(store_data), .mem_size(mem_size),
      .mem_unsigned(mem_unsigned),
      .core_arready(core_arready), .core_rvalid(core_rvalid), .core_rresp(core_rresp),
      .core_awready(core_awready), .core_wready(core_wready), .core_bvalid(core_bvalid),
      .core_bresp(core_bresp), .instr_rdata(instr_rdata), .load_data(load_data),
      .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot), .m_axi_arvalid(m_axi_arvalid),
      .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
      .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
      .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot), .m_axi_awvalid(m_axi_awvalid),
      .m_axi_awready(m_axi_awready), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
      .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
      .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
   );

   // Handshake and pulse counters, sampled mid-cycle.
   always @(negedge clk) if (rst_n) begin
      if (m_axi_arvalid && m_axi_arready) ar_cnt++;
      if (m_axi_awvalid && m_axi_awready) aw_cnt++;
      if (m_axi_wvalid && m_axi_wready)   w_cnt++;
      if (m_axi_bvalid && m_axi_bready)   b_cnt++;
      if (core_rvalid) rv_cnt++;
      if (core_bvalid) bv_cnt++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs;
      req_arvalid = 0; req_rready = 1; req_awvalid = 0; req_wvalid = 0; req_bready = 1;
      data_access = 0; mem_unsigned = 0; pc = '0; data_addr = '0; store_data = '0;
      mem_size = 2'b10;
      m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = '0; m_axi_rresp = '0;
      m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = '0;
   endtask

   task automatic test_reset;
      logic [12:0] ctl;
      clear_inputs();
      rst_n = 0;
      #3;
      ctl = {m_axi_arvalid, m_axi_rready, m_axi_awvalid, m_axi_wvalid, m_axi_bready,
             core_arready, core_rvalid, core_awready, core_wready, core_bvalid,
             core_rresp, core_bresp[0]};
      vectors++;
      if (ctl !== '0) begin
         miscompares++; $display("FAIL reset_ctl: got %b expected 0", ctl);
      end
      vectors++;
      if ({instr_rdata, load_data, m_axi_araddr, m_axi_wstrb} !== '0) begin
         miscompares++;
         $display("FAIL reset_data: got %h %h %h %h expected 0", instr_rdata, load_data,
                  m_axi_araddr, m_axi_wstrb);
      end
      tick(); tick();
      rst_n = 1;
      tick();
   endtask

   task automatic test_fetch(input logic [31:0] pc_v, input int delay, input logic [31:0] rdata_v);
      int a0, r0;
      a0 = ar_cnt; r0 = rv_cnt;
      data_access = 0; pc = pc_v; req_arvalid = 1;
      tick();
      vectors++;
      if ({m_axi_arvalid, m_axi_arprot, m_axi_araddr} !== {1'b1, 3'b100, pc_v}) begin
         miscompares++;
         $display("FAIL fetch_ar: got %b %b %h expected 1 100 %h", m_axi_arvalid, m_axi_arprot,
                  m_axi_araddr, pc_v);
      end
      for (int i = 0; i < delay; i++) begin
         tick();
         vectors++;
         if ({m_axi_arvalid, core_arready} !== 2'b10) begin
            miscompares++;
            $display("FAIL fetch_ar_hold: got %b expected 10", {m_axi_arvalid, core_arready});
         end
      end
      m_axi_arready = 1;
      #1;
      vectors++;
      if (core_arready !== 1'b1) begin
         miscompares++; $display("FAIL fetch_core_arready: got %b expected 1", core_arready);
      end
      tick();
      m_axi_arready = 0;
      vectors++;
      if ({m_axi_arvalid, m_axi_rready} !== 2'b01) begin
         miscompares++;
         $display("FAIL fetch_rd_data: got %b expected 01", {m_axi_arvalid, m_axi_rready});
      end
      m_axi_rvalid = 1; m_axi_rdata = rdata_v; m_axi_rresp = 2'b00;
      tick();
      m_axi_rvalid = 0; req_arvalid = 0;
      vectors++;
      if ({core_rvalid, core_rresp, instr_rdata, m_axi_rready} !== {1'b1, 2'b00, rdata_v, 1'b0}) begin
         miscompares++;
         $display("FAIL fetch_resp: got %b %b %h expected 1 00 %h", core_rvalid, core_rresp,
                  instr_rdata, rdata_v);
      end
      tick();
      vectors++;
      if ({core_rvalid, 32'(ar_cnt - a0), 32'(rv_cnt - r0)} !== {1'b0, 32'd1, 32'd1}) begin
         miscompares++;
         $display("FAIL fetch_counts: got rvalid=%b ar=%0d rv=%0d expected 0 1 1", core_rvalid,
                  ar_cnt - a0, rv_cnt - r0);
      end
   endtask

   task automatic test_load(input logic [31:0] addr, input logic [1:0] size, input logic uns,
                            input logic [31:0] rdata_v, input logic [31:0] exp_load);
      data_access = 1; data_addr = addr; mem_size = size; mem_unsigned = uns; req_arvalid = 1;
      tick();
      vectors++;
      if ({m_axi_arvalid, m_axi_arprot, m_axi_araddr} !== {1'b1, 3'b000, addr & 32'hFFFF_FFFC}) begin
         miscompares++;
         $display("FAIL load_ar %h: got %b %b %h expected 1 000 %h", addr, m_axi_arvalid,
                  m_axi_arprot, m_axi_araddr, addr & 32'hFFFF_FFFC);
      end
      m_axi_arready = 1;
      tick();
      m_axi_arready = 0; m_axi_rvalid = 1; m_axi_rdata = rdata_v; m_axi_rresp = 2'b00;
      tick();
      m_axi_rvalid = 0; req_arvalid = 0;
      vectors++;
      if ({core_rvalid, load_data, instr_rdata} !== {1'b1, exp_load, rdata_v}) begin
         miscompares++;
         $display("FAIL load_data %h: got %b %h %h expected 1 %h %h", addr, core_rvalid,
                  load_data, instr_rdata, exp_load, rdata_v);
      end
      tick();
   endtask

   task automatic test_store_half;
      int b0, bv0;
      b0 = b_cnt; bv0 = bv_cnt;
      data_access = 1; data_addr = 32'h302; mem_size = 2'b01; store_data = 32'h1234ABCD;
      req_awvalid = 1; req_wvalid = 1;
      tick();
      vectors++;
      if ({m_axi_awvalid, m_axi_wvalid, m_axi_awaddr, m_axi_awprot, m_axi_wstrb, m_axi_wdata}
          !== {2'b11, 32'h300, 3'b000, 4'b1100, 32'hABCDABCD}) begin
         miscompares++;
         $display("FAIL sh_req: got %b%b %h %b %b %h expected 11 300 000 1100 abcdabcd",
                  m_axi_awvalid, m_axi_wvalid, m_axi_awaddr, m_axi_awprot, m_axi_wstrb, m_axi_wdata);
      end
      m_axi_awready = 1;
      #1;
      vectors++;
      if ({core_awready, core_wready} !== 2'b10) begin
         miscompares++; $display("FAIL sh_core_awready: got %b expected 10", {core_awready, core_wready});
      end
      tick();
      m_axi_awready = 0;
      tick(); tick();
      vectors++;
      if ({m_axi_awvalid, m_axi_wvalid} !== 2'b01) begin
         miscompares++;
         $display("FAIL sh_w_pending: got %b expected 01", {m_axi_awvalid, m_axi_wvalid});
      end
      m_axi_wready = 1;
      #1;
      vectors++;
      if ({core_awready, core_wready} !== 2'b01) begin
         miscompares++; $display("FAIL sh_core_wready: got %b expected 01", {core_awready, core_wready});
      end
      tick();
      m_axi_wready = 0;
      vectors++;
      if ({m_axi_wvalid, m_axi_bready, core_bvalid} !== 3'b010) begin
         miscompares++;
         $display("FAIL sh_wr_resp: got %b expected 010", {m_axi_wvalid, m_axi_bready, core_bvalid});
      end
      m_axi_bvalid = 1; m_axi_bresp = 2'b00;
      tick();
      m_axi_bvalid = 0; req_awvalid = 0; req_wvalid = 0;
      vectors++;
      if ({core_bvalid, core_bresp, core_rvalid} !== 4'b1000) begin
         miscompares++;
         $display("FAIL sh_bvalid: got %b %b %b expected 1 00 0", core_bvalid, core_bresp, core_rvalid);
      end
      tick();
      vectors++;
      if ({core_bvalid, 32'(b_cnt - b0), 32'(bv_cnt - bv0)} !== {1'b0, 32'd1, 32'd1}) begin
         miscompares++;
         $display("FAIL sh_counts: got bvalid=%b b=%0d bv=%0d expected 0 1 1", core_bvalid,
                  b_cnt - b0, bv_cnt - bv0);
      end
   endtask

   task automatic test_store_byte;
      data_access = 1; data_addr = 32'h503; mem_size = 2'b00; store_data = 32'h1234ABCD;
      req_awvalid = 1; req_wvalid = 1;
      tick();
      vectors++;
      if ({m_axi_awaddr, m_axi_wstrb, m_axi_wdata} !== {32'h500, 4'b1000, 32'hCDCDCDCD}) begin
         miscompares++;
         $display("FAIL sb_req: got %h %b %h expected 500 1000 cdcdcdcd", m_axi_awaddr,
                  m_axi_wstrb, m_axi_wdata);
      end
      m_axi_awready = 1; m_axi_wready = 1;
      tick();
      m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 1; m_axi_bresp = 2'b10;
      tick();
      m_axi_bvalid = 0; req_awvalid = 0; req_wvalid = 0;
      vectors++;
      if ({core_bvalid, core_bresp} !== 3'b110) begin
         miscompares++; $display("FAIL sb_bresp: got %b %b expected 1 10", core_bvalid, core_bresp);
      end
      tick();
   endtask

   task automatic test_misaligned;
      int a0, w0;
      a0 = ar_cnt; w0 = aw_cnt;
      data_access = 1; data_addr = 32'h401; mem_size = 2'b10; req_arvalid = 1;
      tick();
      req_arvalid = 0;
      vectors++;
      if ({core_rvalid, core_rresp, m_axi_arvalid} !== 4'b1100) begin
         miscompares++;
         $display("FAIL lw_misaligned: got %b %b %b expected 1 10 0", core_rvalid, core_rresp,
                  m_axi_arvalid);
      end
      tick();
      vectors++;
      if ({core_rvalid, 32'(ar_cnt - a0)} !== {1'b0, 32'd0}) begin
         miscompares++;
         $display("FAIL lw_no_ar: got rvalid=%b ar=%0d expected 0 0", core_rvalid, ar_cnt - a0);
      end
      data_addr = 32'h600; mem_size = 2'b11; req_awvalid = 1; req_wvalid = 1;
      tick();
      req_awvalid = 0; req_wvalid = 0;
      vectors++;
      if ({core_bvalid, core_bresp, m_axi_awvalid, m_axi_wvalid} !== 5'b11000) begin
         miscompares++;
         $display("FAIL st_illegal_size: got %b %b %b%b expected 1 10 00", core_bvalid,
                  core_bresp, m_axi_awvalid, m_axi_wvalid);
      end
      tick();
      data_access = 0; pc = 32'h102; req_arvalid = 1;
      tick();
      req_arvalid = 0;
      vectors++;
      if ({core_rvalid, core_rresp, m_axi_arvalid} !== 4'b1100) begin
         miscompares++;
         $display("FAIL fetch_misaligned: got %b %b %b expected 1 10 0", core_rvalid, core_rresp,
                  m_axi_arvalid);
      end
      tick();
      vectors++;
      if ({32'(ar_cnt - a0), 32'(aw_cnt - w0)} !== {32'd0, 32'd0}) begin
         miscompares++;
         $display("FAIL misaligned_no_bus: got ar=%0d aw=%0d expected 0 0", ar_cnt - a0, aw_cnt - w0);
      end
   endtask

   task automatic test_timeout;
      int b0;
      b0 = b_cnt;
      data_access = 1; data_addr = 32'h700; mem_size = 2'b10; store_data = 32'hCAFEF00D;
      req_awvalid = 1; req_wvalid = 1;
      tick();
      vectors++;
      if ({m_axi_wstrb, m_axi_wdata} !== {4'b1111, 32'hCAFEF00D}) begin
         miscompares++;
         $display("FAIL sw_fmt: got %b %h expected 1111 cafef00d", m_axi_wstrb, m_axi_wdata);
      end
      m_axi_awready = 1; m_axi_wready = 1;
      tick();
      m_axi_awready = 0; m_axi_wready = 0;
      for (int i = 0; i < 7; i++) begin
         vectors++;
         if ({m_axi_bready, core_bvalid} !== 2'b10) begin
            miscompares++;
            $display("FAIL timeout_wait cycle %0d: got %b expected 10", i, {m_axi_bready, core_bvalid});
         end
         tick();
      end
      vectors++;
      if ({m_axi_bready, core_bvalid} !== 2'b10) begin
         miscompares++;
         $display("FAIL timeout_last_wait: got %b expected 10", {m_axi_bready, core_bvalid});
      end
      tick();
      req_awvalid = 0; req_wvalid = 0;
      vectors++;
      if ({core_bvalid, core_bresp, m_axi_bready} !== 4'b1110) begin
         miscompares++;
         $display("FAIL timeout_resp: got %b %b %b expected 1 11 0", core_bvalid, core_bresp,
                  m_axi_bready);
      end
      tick();
      m_axi_bvalid = 1;
      tick();
      m_axi_bvalid = 0;
      vectors++;
      if ({core_bvalid, m_axi_bready, 32'(b_cnt - b0)} !== {2'b00, 32'd0}) begin
         miscompares++;
         $display("FAIL late_bvalid: got bvalid=%b bready=%b b=%0d expected 0 0 0", core_bvalid,
                  m_axi_bready, b_cnt - b0);
      end
   endtask

   task automatic test_reset_mid;
      data_access = 0; pc = 32'h600; req_arvalid = 1;
      tick();
      m_axi_arready = 1;
      tick();
      m_axi_arready = 0;
      vectors++;
      if (m_axi_rready !== 1'b1) begin
         miscompares++; $display("FAIL mid_rd_data: got rready=%b expected 1", m_axi_rready);
      end
      #2;
      rst_n = 0;
      #1;
      vectors++;
      if ({m_axi_arvalid, m_axi_rready, m_axi_awvalid, m_axi_wvalid, m_axi_bready,
           core_rvalid, core_bvalid, core_arready, m_axi_araddr, instr_rdata} !== '0) begin
         miscompares++;
         $display("FAIL async_reset: got ar=%b r=%b rv=%b araddr=%h expected all 0",
                  m_axi_arvalid, m_axi_rready, core_rvalid, m_axi_araddr);
      end
      req_arvalid = 0;
      tick();
      rst_n = 1;
      tick();
      test_fetch(32'h104, 0, 32'h12345678);
   endtask

   initial begin
      test_reset();
      test_fetch(32'h100, 2, 32'h00500093);
      test_load(32'h203, 2'b00, 1'b0, 32'h80FFFFFF, 32'hFFFFFF80);
      test_load(32'h203, 2'b00, 1'b1, 32'h80FFFFFF, 32'h00000080);
      test_load(32'h202, 2'b01, 1'b0, 32'h80FFFFFF, 32'hFFFF80FF);
      test_load(32'h202, 2'b01, 1'b1, 32'h80FFFFFF, 32'h000080FF);
      test_load(32'h201, 2'b00, 1'b0, 32'h11223344, 32'h00000033);
      test_load(32'h400, 2'b10, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF);
      test_store_half();
      test_store_byte();
      test_misaligned();
      test_timeout();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
